// File: rtl/hazard_controller_pkg.sv
// Shared encodings for the pipeline hazard controller: result select, forward
// select, PC source and wait-state FSM states.
package hazard_controller_pkg;

    typedef enum logic [1:0] {
        RES_ALU  = 2'b00,
        RES_LOAD = 2'b01,
        RES_PC4  = 2'b10,
        RES_IMM  = 2'b11
    } result_src_e;

    typedef enum logic [1:0] {
        FWD_RF    = 2'b00,
        FWD_W     = 2'b01,
        FWD_M_ALU = 2'b10,
        FWD_M_IMM = 2'b11
    } fwd_e;

    typedef enum logic [1:0] {
        PC_SEQ  = 2'b00,
        PC_BR   = 2'b01,
        PC_JALR = 2'b10
    } pc_src_e;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } state_e;

endpackage

// File: rtl/hazard_controller_forward_unit.sv
// Combinational forward-select for one E-stage source operand; M beats W,
// and x0 never forwards.
module hazard_controller_forward_unit
    import hazard_controller_pkg::*;
(
    input  logic [4:0] i_rs_e,
    input  logic [4:0] i_rd_m,
    input  logic [4:0] i_rd_w,
    input  logic       i_reg_write_m,
    input  logic       i_reg_write_w,
    input  logic [1:0] i_result_src_m,
    output fwd_e       o_fwd
);

    logic w_match_m;
    logic w_match_w;

    assign w_match_m = i_reg_write_m && (i_rs_e != 5'd0) && (i_rd_m == i_rs_e);
    assign w_match_w = i_reg_write_w && (i_rs_e != 5'd0) && (i_rd_w == i_rs_e);

    always_comb begin
        o_fwd = FWD_RF;
        if (w_match_m) begin
            // A PC+4 producer in M never reaches here in practice (jal/jalr
            // flush E), so it deliberately leaves the register-file path.
            if (i_result_src_m == RES_ALU || i_result_src_m == RES_LOAD) begin
                o_fwd = FWD_M_ALU;
            end else if (i_result_src_m == RES_IMM) begin
                o_fwd = FWD_M_IMM;
            end
        end else if (w_match_w) begin
            o_fwd = FWD_W;
        end
    end

endmodule

// File: rtl/hazard_controller.sv
// Stall/flush/forward sequencing for the 5-stage pipeline, plus a data-memory
// wait-state freeze with watchdog and saturating performance counters.
module hazard_controller
    import hazard_controller_pkg::*;
#(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       Rs1D,
    input  logic [4:0]       Rs2D,
    input  logic [4:0]       Rs1E,
    input  logic [4:0]       Rs2E,
    input  logic [4:0]       RdE,
    input  logic [4:0]       RdM,
    input  logic [4:0]       RdW,
    input  logic             RegWriteM,
    input  logic             RegWriteW,
    input  logic [1:0]       ResultSrcE,
    input  logic [1:0]       ResultSrcM,
    input  logic             MemWriteM,
    input  logic [1:0]       PCSrcE,
    input  logic             mem_ack,
    output logic             StallF,
    output logic             StallD,
    output logic             StallE,
    output logic             StallM,
    output logic             StallW,
    output logic             FlushD,
    output logic             FlushE,
    output logic [1:0]       ForwardAE,
    output logic [1:0]       ForwardBE,
    output logic             mem_err,
    output logic [CNT_W-1:0] lu_stall_cnt,
    output logic [CNT_W-1:0] freeze_cnt,
    output logic [CNT_W-1:0] flush_cnt,
    output state_e           dbg_state
);

    localparam int WAIT_W = $clog2(TIMEOUT) + 1;
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);
    localparam logic [WAIT_W-1:0] WAIT_ONE  = WAIT_W'(1);
    localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);

    state_e            r_state;
    logic [WAIT_W-1:0] r_wait_cnt;
    logic              r_mem_err;
    logic [CNT_W-1:0]  r_lu_stall_cnt;
    logic [CNT_W-1:0]  r_freeze_cnt;
    logic [CNT_W-1:0]  r_flush_cnt;

    fwd_e w_fwd_a;
    fwd_e w_fwd_b;
    logic w_lw_stall;
    logic w_mem_acc;
    logic w_timeout;
    logic w_freeze;
    logic w_redirect;

    hazard_controller_forward_unit u_fwd_a (
        .i_rs_e        (Rs1E),
        .i_rd_m        (RdM),
        .i_rd_w        (RdW),
        .i_reg_write_m (RegWriteM),
        .i_reg_write_w (RegWriteW),
        .i_result_src_m(ResultSrcM),
        .o_fwd         (w_fwd_a)
    );

    hazard_controller_forward_unit u_fwd_b (
        .i_rs_e        (Rs2E),
        .i_rd_m        (RdM),
        .i_rd_w        (RdW),
        .i_reg_write_m (RegWriteM),
        .i_reg_write_w (RegWriteW),
        .i_result_src_m(ResultSrcM),
        .o_fwd         (w_fwd_b)
    );

    assign w_lw_stall = (ResultSrcE == RES_LOAD) && (RdE != 5'd0) &&
                        ((RdE == Rs1D) || (RdE == Rs2D));
    assign w_mem_acc  = MemWriteM || (ResultSrcM == RES_LOAD);
    assign w_redirect = (PCSrcE != PC_SEQ);
    assign w_timeout  = (r_state == ST_WAIT) && (r_wait_cnt == WAIT_LAST);

    // The freeze starts in the very cycle the access is seen unacknowledged,
    // and reset drops it at once even though the request may still be present.
    always_comb begin
        w_freeze = 1'b0;
        if (!rst) begin
            if (r_state == ST_IDLE) begin
                w_freeze = w_mem_acc && !mem_ack;
            end else begin
                w_freeze = !mem_ack && !w_timeout;
            end
        end
    end

    // r_wait_cnt holds the number of freeze cycles already spent on this access.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_wait_cnt <= '0;
            r_mem_err  <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_mem_acc && !mem_ack) begin
                        r_state    <= ST_WAIT;
                        r_wait_cnt <= WAIT_ONE;
                    end else begin
                        r_wait_cnt <= '0;
                    end
                end
                ST_WAIT: begin
                    if (mem_ack) begin
                        r_state    <= ST_IDLE;
                        r_wait_cnt <= '0;
                    end else if (w_timeout) begin
                        r_state    <= ST_IDLE;
                        r_wait_cnt <= '0;
                        r_mem_err  <= 1'b1;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + WAIT_ONE;
                    end
                end
                default: begin
                    r_state    <= ST_IDLE;
                    r_wait_cnt <= '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_lu_stall_cnt <= '0;
            r_freeze_cnt   <= '0;
            r_flush_cnt    <= '0;
        end else begin
            if (w_lw_stall && !w_freeze && r_lu_stall_cnt != '1) begin
                r_lu_stall_cnt <= r_lu_stall_cnt + CNT_ONE;
            end
            if (w_freeze && r_freeze_cnt != '1) begin
                r_freeze_cnt <= r_freeze_cnt + CNT_ONE;
            end
            if (w_redirect && !w_freeze && r_flush_cnt != '1) begin
                r_flush_cnt <= r_flush_cnt + CNT_ONE;
            end
        end
    end

    assign StallE = w_freeze;
    assign StallM = w_freeze;
    assign StallW = w_freeze;
    assign StallF = w_lw_stall || w_freeze;
    assign StallD = w_lw_stall || w_freeze;
    // Flushes wait out a freeze; E still holds the redirect when it lifts.
    assign FlushD = w_redirect && !w_freeze;
    assign FlushE = (w_lw_stall || w_redirect) && !w_freeze;

    assign ForwardAE    = w_fwd_a;
    assign ForwardBE    = w_fwd_b;
    assign mem_err      = r_mem_err;
    assign lu_stall_cnt = r_lu_stall_cnt;
    assign freeze_cnt   = r_freeze_cnt;
    assign flush_cnt    = r_flush_cnt;
    assign dbg_state    = r_state;

endmodule

// File: tb/tb_hazard_controller.sv
// Directed bench for hazard_controller: forwarding, load-use, wait-state freeze,
// flush suppression, watchdog timeout and asynchronous reset mid-wait.
module tb_hazard_controller;
    import hazard_controller_pkg::*;

    localparam int TIMEOUT = 16;
    localparam int CNT_W   = 32;

    logic             clk;
    logic             rst;
    logic [4:0]       Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
    logic             RegWriteM, RegWriteW;
    logic [1:0]       ResultSrcE, ResultSrcM;
    logic             MemWriteM;
    logic [1:0]       PCSrcE;
    logic             mem_ack;
    logic             StallF, StallD, StallE, StallM, StallW;
    logic             FlushD, FlushE;
    logic [1:0]       ForwardAE, ForwardBE;
    logic             mem_err;
    logic [CNT_W-1:0] lu_stall_cnt, freeze_cnt, flush_cnt;
    state_e           dbg_state;

    int vecs;
    int fails;

    hazard_controller #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst),
        .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE),
        .RdM(RdM), .RdW(RdW), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
        .ResultSrcE(ResultSrcE), .ResultSrcM(ResultSrcM), .MemWriteM(MemWriteM),
        .PCSrcE(PCSrcE), .mem_ack(mem_ack),
        .StallF(StallF), .StallD(StallD), .StallE(StallE), .StallM(StallM),
        .StallW(StallW), .FlushD(FlushD), .FlushE(FlushE),
        .ForwardAE(ForwardAE), .ForwardBE(ForwardBE), .mem_err(mem_err),
        .lu_stall_cnt(lu_stall_cnt), .freeze_cnt(freeze_cnt), .flush_cnt(flush_cnt),
        .dbg_state(dbg_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "bench time limit");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vecs++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Inputs change 1 time unit after the rising edge; checks follow 1 unit later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        Rs1D = 0; Rs2D = 0; Rs1E = 0; Rs2E = 0; RdE = 0; RdM = 0; RdW = 0;
        RegWriteM = 0; RegWriteW = 0; ResultSrcE = RES_ALU; ResultSrcM = RES_ALU;
        MemWriteM = 0; PCSrcE = PC_SEQ; mem_ack = 0;
    endtask

    task automatic chk_stalls(input string tag, input logic f, input logic e);
        chk({tag, "_StallF"}, 64'(StallF), 64'(f));
        chk({tag, "_StallD"}, 64'(StallD), 64'(f));
        chk({tag, "_StallE"}, 64'(StallE), 64'(e));
        chk({tag, "_StallM"}, 64'(StallM), 64'(e));
        chk({tag, "_StallW"}, 64'(StallW), 64'(e));
    endtask

    initial begin
        vecs = 0;
        fails = 0;
        idle_inputs();
        rst = 1'b1;
        tick();
        tick();
        #1;
        chk("rst_state", 64'(dbg_state), 64'(ST_IDLE));
        chk("rst_mem_err", 64'(mem_err), 64'd0);
        chk("rst_lu", 64'(lu_stall_cnt), 64'd0);
        chk("rst_freeze", 64'(freeze_cnt), 64'd0);
        chk("rst_flush", 64'(flush_cnt), 64'd0);
        chk_stalls("rst", 1'b0, 1'b0);
        rst = 1'b0;
        tick();

        // Forwarding: M ALU result beats W, x0 never forwards.
        RegWriteM = 1; RdM = 5; ResultSrcM = RES_ALU; RegWriteW = 1; RdW = 5; Rs1E = 5;
        #1;
        chk("fwdA_m_alu", 64'(ForwardAE), 64'b10);
        chk("fwdB_none", 64'(ForwardBE), 64'b00);
        Rs1E = 0;
        #1;
        chk("fwdA_x0", 64'(ForwardAE), 64'b00);
        // lui in M feeds B through the immediate path.
        RdM = 7; ResultSrcM = RES_IMM; Rs2E = 7; RdW = 9; Rs1E = 9;
        #1;
        chk("fwdB_m_imm", 64'(ForwardBE), 64'b11);
        chk("fwdA_w", 64'(ForwardAE), 64'b01);
        RegWriteM = 0; RdW = 7;
        #1;
        chk("fwdB_w_only", 64'(ForwardBE), 64'b01);
        RegWriteM = 1; RdM = 7; ResultSrcM = RES_PC4;
        #1;
        chk("fwdB_m_pc4", 64'(ForwardBE), 64'b00);
        idle_inputs();
        tick();

        // Load-use: one bubble.
        ResultSrcE = RES_LOAD; RdE = 3; Rs2D = 3;
        #1;
        chk_stalls("lu", 1'b1, 1'b0);
        chk("lu_FlushE", 64'(FlushE), 64'd1);
        chk("lu_FlushD", 64'(FlushD), 64'd0);
        tick();
        chk("lu_cnt1", 64'(lu_stall_cnt), 64'd1);
        ResultSrcE = RES_ALU; RdE = 0;
        #1;
        chk_stalls("lu_after", 1'b0, 1'b0);
        chk("lu_after_FlushE", 64'(FlushE), 64'd0);
        tick();
        chk("lu_cnt_hold", 64'(lu_stall_cnt), 64'd1);

        // Load in M with three wait cycles.
        RegWriteM = 1; RdM = 4; ResultSrcM = RES_LOAD; mem_ack = 0;
        #1;
        chk_stalls("wait0", 1'b1, 1'b1);
        tick();
        chk("wait1_state", 64'(dbg_state), 64'(ST_WAIT));
        chk_stalls("wait1", 1'b1, 1'b1);
        tick();
        chk_stalls("wait2", 1'b1, 1'b1);
        tick();
        mem_ack = 1;
        #1;
        chk_stalls("ack", 1'b0, 1'b0);
        chk("ack_freeze_cnt", 64'(freeze_cnt), 64'd3);
        tick();
        idle_inputs();
        #1;
        chk("ack_state", 64'(dbg_state), 64'(ST_IDLE));
        chk("ack_freeze_cnt_hold", 64'(freeze_cnt), 64'd3);
        chk_stalls("post_ack", 1'b0, 1'b0);

        // Redirect raised during a freeze fires only in the release cycle.
        ResultSrcM = RES_LOAD; RdM = 6; RegWriteM = 1; PCSrcE = PC_BR;
        #1;
        chk("frz_FlushD_a", 64'(FlushD), 64'd0);
        chk("frz_FlushE_a", 64'(FlushE), 64'd0);
        tick();
        chk("frz_FlushD_b", 64'(FlushD), 64'd0);
        chk("frz_FlushE_b", 64'(FlushE), 64'd0);
        chk("frz_flush_cnt", 64'(flush_cnt), 64'd0);
        tick();
        mem_ack = 1;
        #1;
        chk("rel_FlushD", 64'(FlushD), 64'd1);
        chk("rel_FlushE", 64'(FlushE), 64'd1);
        tick();
        idle_inputs();
        #1;
        chk("rel_flush_cnt", 64'(flush_cnt), 64'd1);
        chk("rel_freeze_cnt", 64'(freeze_cnt), 64'd5);

        // Load-use together with a jalr redirect: flush and stall both asserted.
        ResultSrcE = RES_LOAD; RdE = 3; Rs1D = 3; PCSrcE = PC_JALR;
        #1;
        chk("both_FlushD", 64'(FlushD), 64'd1);
        chk("both_FlushE", 64'(FlushE), 64'd1);
        chk_stalls("both", 1'b1, 1'b0);
        tick();
        idle_inputs();
        #1;
        chk("both_lu_cnt", 64'(lu_stall_cnt), 64'd2);
        chk("both_flush_cnt", 64'(flush_cnt), 64'd2);

        // Watchdog: no ack, 15 frozen cycles then a forced release.
        ResultSrcM = RES_LOAD; RdM = 8; RegWriteM = 1;
        for (int i = 0; i < TIMEOUT - 1; i++) begin
            #1;
            chk($sformatf("to_freeze_%0d", i), 64'(StallM), 64'd1);
            tick();
        end
        #1;
        chk("to_release", 64'(StallM), 64'd0);
        chk("to_release_StallF", 64'(StallF), 64'd0);
        chk("to_err_before", 64'(mem_err), 64'd0);
        tick();
        idle_inputs();
        #1;
        chk("to_mem_err", 64'(mem_err), 64'd1);
        chk("to_state", 64'(dbg_state), 64'(ST_IDLE));
        chk("to_freeze_cnt", 64'(freeze_cnt), 64'd20);
        tick();
        chk("to_mem_err_sticky", 64'(mem_err), 64'd1);

        // Asynchronous reset in the middle of a wait.
        ResultSrcM = RES_LOAD; RdM = 8; RegWriteM = 1;
        tick();
        tick();
        chk("rw_state", 64'(dbg_state), 64'(ST_WAIT));
        #2;
        rst = 1'b1;
        #1;
        chk_stalls("rw", 1'b0, 1'b0);
        chk("rw_state_idle", 64'(dbg_state), 64'(ST_IDLE));
        chk("rw_mem_err", 64'(mem_err), 64'd0);
        chk("rw_lu", 64'(lu_stall_cnt), 64'd0);
        chk("rw_freeze", 64'(freeze_cnt), 64'd0);
        chk("rw_flush", 64'(flush_cnt), 64'd0);
        idle_inputs();
        tick();
        rst = 1'b0;
        tick();
        chk("rw_after_state", 64'(dbg_state), 64'(ST_IDLE));
        chk("rw_after_freeze", 64'(freeze_cnt), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, fails);
        $finish;
    end

endmodule
